// File: rtl/avst_sort_pkg.sv
// Shared types and the compare helper for the Avalon-ST packet sorter.
package avst_sort_pkg;

    localparam int unsigned CMP_W = 64;

    typedef enum logic [1:0] {IDLE_S, WRITE_S, SORT_S, READ_S} state_t;

    // Operands arrive already extended to CMP_W (sign- or zero-extended by the caller).
    function automatic logic out_of_order(input logic [CMP_W-1:0] a,
                                          input logic [CMP_W-1:0] b,
                                          input logic             desc,
                                          input logic             signed_cmp);
        logic gt, lt;
        if (signed_cmp) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return desc ? lt : gt;
    endfunction

endpackage

// File: rtl/sort_dpram.sv
// True dual-port RAM, read-first, one-cycle registered read on both ports.
module sort_dpram #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic [DWIDTH-1:0] a_rdata,
    input  logic              b_we,
    input  logic [AW-1:0]     b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic [DWIDTH-1:0] b_rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/avst_pkt_sorter.sv
// Avalon-ST packet sorter: buffer one packet, odd-even transposition sort in RAM, stream it out.
module avst_pkt_sorter
    import avst_sort_pkg::*;
#(
    parameter int unsigned DWIDTH      = 16,
    parameter int unsigned MAX_PKT_LEN = 16,
    parameter bit          SIGNED_CMP  = 1'b0
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    input  logic              sort_desc_i,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              pkt_err_o,
    output logic              busy_o
);

    localparam int unsigned AW = $clog2(MAX_PKT_LEN);
    localparam int unsigned LW = $clog2(MAX_PKT_LEN + 1);

    state_t            state, state_nxt;
    logic [LW-1:0]     len, pass, nxt;
    logic [LW:0]       pair_i;
    logic              desc, dropping, cmp_ph, primed, err;
    logic [DWIDTH-1:0] a_rdata, b_rdata, a_wdata, b_wdata;
    logic [AW-1:0]     a_addr, b_addr;
    logic              a_we, b_we;
    logic [CMP_W-1:0]  a_ext, b_ext;
    logic accept, sop_start, restart, overflow, wr_beat, drop_end;
    logic pair_go, pass_end, sort_done, swap, tx, load, read_done;

    assign accept    = snk_valid_i & snk_ready_o;
    assign sop_start = accept & snk_startofpacket_i &
                       ((state == IDLE_S) | ((state == WRITE_S) & ~dropping));
    assign restart   = sop_start & (state == WRITE_S);
    assign overflow  = accept & (state == WRITE_S) & ~dropping & ~snk_startofpacket_i &
                       (len == LW'(MAX_PKT_LEN));
    assign wr_beat   = accept & (state == WRITE_S) & ~dropping & ~snk_startofpacket_i &
                       (len != LW'(MAX_PKT_LEN));
    assign drop_end  = accept & dropping & snk_endofpacket_i;

    assign pair_go   = (state == SORT_S) & ~cmp_ph & ((pair_i + 1'b1) < {1'b0, len});
    assign pass_end  = (state == SORT_S) & ~cmp_ph & ~pair_go;
    assign sort_done = pass_end & (pass == len - 1'b1);

    assign a_ext = {{(CMP_W-DWIDTH){SIGNED_CMP & a_rdata[DWIDTH-1]}}, a_rdata};
    assign b_ext = {{(CMP_W-DWIDTH){SIGNED_CMP & b_rdata[DWIDTH-1]}}, b_rdata};
    assign swap  = out_of_order(a_ext, b_ext, desc, SIGNED_CMP);

    assign tx        = src_valid_o & src_ready_i;
    assign load      = (state == READ_S) & primed & (nxt < len) & (~src_valid_o | src_ready_i);
    assign read_done = tx & src_endofpacket_o;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state <= IDLE_S;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE_S:  if (sop_start) state_nxt = snk_endofpacket_i ? READ_S : WRITE_S;
            WRITE_S: begin
                if (sop_start)                           state_nxt = snk_endofpacket_i ? READ_S : WRITE_S;
                else if (overflow && snk_endofpacket_i)  state_nxt = IDLE_S;
                else if (drop_end)                       state_nxt = IDLE_S;
                else if (wr_beat && snk_endofpacket_i)   state_nxt = SORT_S;
            end
            SORT_S:  if (sort_done) state_nxt = READ_S;
            READ_S:  if (read_done) state_nxt = IDLE_S;
            default: state_nxt = IDLE_S;
        endcase
    end

    always_comb begin
        snk_ready_o = (state == IDLE_S) | (state == WRITE_S);
        busy_o      = (state == SORT_S) | (state == READ_S);
    end

    // Port A serves the sink writes, the lower element of each pair and the output prefetch.
    always_comb begin
        a_we    = 1'b0;
        a_addr  = '0;
        a_wdata = snk_data_i;
        b_we    = 1'b0;
        b_addr  = '0;
        b_wdata = '0;
        if (sop_start) begin
            a_we = 1'b1;
        end else if (wr_beat) begin
            a_we   = 1'b1;
            a_addr = AW'(len);
        end
        if (state == SORT_S) begin
            a_addr = AW'(pair_i);
            b_addr = AW'(pair_i + 1'b1);
            if (cmp_ph && swap) begin
                a_we    = 1'b1;
                a_wdata = b_rdata;
                b_we    = 1'b1;
                b_wdata = a_rdata;
            end
        end else if (state == READ_S) begin
            a_addr = load ? AW'(nxt + 1'b1) : AW'(nxt);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            len      <= '0;
            desc     <= 1'b0;
            dropping <= 1'b0;
            err      <= 1'b0;
            pass     <= '0;
            pair_i   <= '0;
            cmp_ph   <= 1'b0;
        end else begin
            err <= restart | overflow;
            if (sop_start) begin
                len  <= LW'(1);
                desc <= sort_desc_i;
            end else if (wr_beat) begin
                len <= len + 1'b1;
            end
            if (overflow)      dropping <= ~snk_endofpacket_i;
            else if (drop_end) dropping <= 1'b0;
            if (state != SORT_S) begin
                pass   <= '0;
                pair_i <= '0;
                cmp_ph <= 1'b0;
            end else if (pair_go) begin
                cmp_ph <= 1'b1;
            end else if (cmp_ph) begin
                cmp_ph <= 1'b0;
                pair_i <= pair_i + 2'd2;
            end else begin
                pass   <= pass + 1'b1;
                pair_i <= {{LW{1'b0}}, ~pass[0]};
            end
        end
    end

    // nxt is the index of the word waiting in the RAM read register behind src_data_o.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            nxt                 <= '0;
            primed              <= 1'b0;
            src_data_o          <= '0;
            src_valid_o         <= 1'b0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
        end else if (state != READ_S) begin
            nxt    <= '0;
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
            if (load) begin
                src_data_o          <= a_rdata;
                src_valid_o         <= 1'b1;
                src_startofpacket_o <= (nxt == '0);
                src_endofpacket_o   <= (nxt == len - 1'b1);
                nxt                 <= nxt + 1'b1;
            end else if (tx) begin
                src_valid_o         <= 1'b0;
                src_startofpacket_o <= 1'b0;
                src_endofpacket_o   <= 1'b0;
            end
        end
    end

    assign pkt_err_o = err;

    sort_dpram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_PKT_LEN)
    ) u_ram (
        .clk     (clk_i),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_rdata (b_rdata)
    );

endmodule

// File: tb/tb_avst_pkt_sorter.sv
// Directed bench: 16-bit unsigned instance plus an 8-bit signed instance for the signed case.
module tb_avst_pkt_sorter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic [15:0] snk_data;
    logic        snk_sop, snk_eop, snk_valid, sort_desc, src_ready;

    logic [15:0] src_data_u;
    logic [7:0]  src_data_s;
    logic snk_ready_u, src_sop_u, src_eop_u, src_valid_u, pkt_err_u, busy_u;
    logic snk_ready_s, src_sop_s, src_eop_s, src_valid_s, pkt_err_s, busy_s;

    logic [15:0] data_m;
    logic        rdy_m, sop_m, eop_m, vld_m, err_m, busy_m;
    assign data_m = sel ? {8'h00, src_data_s} : src_data_u;
    assign rdy_m  = sel ? snk_ready_s : snk_ready_u;
    assign sop_m  = sel ? src_sop_s : src_sop_u;
    assign eop_m  = sel ? src_eop_s : src_eop_u;
    assign vld_m  = sel ? src_valid_s : src_valid_u;
    assign err_m  = sel ? pkt_err_s : pkt_err_u;
    assign busy_m = sel ? busy_s : busy_u;

    avst_pkt_sorter #(.DWIDTH(16), .MAX_PKT_LEN(16), .SIGNED_CMP(1'b0)) u_dut (
        .clk_i               (clk),
        .arst_n_i            (rst_n),
        .snk_data_i          (snk_data),
        .snk_startofpacket_i (snk_sop),
        .snk_endofpacket_i   (snk_eop),
        .snk_valid_i         (snk_valid & ~sel),
        .snk_ready_o         (snk_ready_u),
        .sort_desc_i         (sort_desc),
        .src_data_o          (src_data_u),
        .src_startofpacket_o (src_sop_u),
        .src_endofpacket_o   (src_eop_u),
        .src_valid_o         (src_valid_u),
        .src_ready_i         (src_ready),
        .pkt_err_o           (pkt_err_u),
        .busy_o              (busy_u)
    );

    avst_pkt_sorter #(.DWIDTH(8), .MAX_PKT_LEN(16), .SIGNED_CMP(1'b1)) u_dut_s (
        .clk_i               (clk),
        .arst_n_i            (rst_n),
        .snk_data_i          (snk_data[7:0]),
        .snk_startofpacket_i (snk_sop),
        .snk_endofpacket_i   (snk_eop),
        .snk_valid_i         (snk_valid & sel),
        .snk_ready_o         (snk_ready_s),
        .sort_desc_i         (sort_desc),
        .src_data_o          (src_data_s),
        .src_startofpacket_o (src_sop_s),
        .src_endofpacket_o   (src_eop_s),
        .src_valid_o         (src_valid_s),
        .src_ready_i         (src_ready),
        .pkt_err_o           (pkt_err_s),
        .busy_o              (busy_s)
    );

    int n_checks = 0;
    int n_errors = 0;
    int err_cnt  = 0;
    int vld_cnt  = 0;

    always @(negedge clk) begin
        if (pkt_err_u | pkt_err_s)     err_cnt <= err_cnt + 1;
        if (src_valid_u | src_valid_s) vld_cnt <= vld_cnt + 1;
    end

    logic [15:0] exp_d [32];
    logic [15:0] got_d [32];
    logic        got_sop [32];
    logic        got_eop [32];
    int          got_n, first_cyc, last_cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge; the beat is taken on the posedge in between.
    task automatic send(input logic [15:0] d, input logic sop, input logic eop);
        int n = 0;
        snk_valid = 1'b1;
        snk_data  = d;
        snk_sop   = sop;
        snk_eop   = eop;
        while (!rdy_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
    endtask

    // toggle=1 drives src_ready 1,0,1,0... starting high.
    task automatic recv(input int n, input bit toggle);
        int          cyc = 0;
        logic        held = 1'b0;
        logic [15:0] held_d = '0;
        got_n     = 0;
        first_cyc = -1;
        last_cyc  = -1;
        while (got_n < n && cyc < 2000) begin
            src_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (held) begin
                check_val("stall_valid", 32'(vld_m), 32'd1);
                check_val("stall_data", 32'(data_m), 32'(held_d));
            end
            held = 1'b0;
            if (vld_m) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (src_ready) begin
                    got_d[got_n]   = data_m;
                    got_sop[got_n] = sop_m;
                    got_eop[got_n] = eop_m;
                    got_n++;
                    last_cyc = cyc;
                end else begin
                    held   = 1'b1;
                    held_d = data_m;
                end
            end
            @(negedge clk);
            cyc++;
        end
        src_ready = 1'b0;
        if (cyc >= 2000) check_val("recv_timeout", 32'(got_n), 32'(n));
    endtask

    task automatic check_pkt(input string tag, input int n);
        check_val({tag, "_count"}, 32'(got_n), 32'(n));
        for (int k = 0; k < n; k++) begin
            check_val({tag, "_data"}, 32'(got_d[k]), 32'(exp_d[k]));
            check_val({tag, "_sop"}, 32'(got_sop[k]), 32'(k == 0));
            check_val({tag, "_eop"}, 32'(got_eop[k]), 32'(k == n - 1));
        end
    endtask

    initial begin
        int e0, v0;
        sel = 1'b0; snk_data = '0; snk_sop = 1'b0; snk_eop = 1'b0; snk_valid = 1'b0;
        sort_desc = 1'b0; src_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_snk_ready", 32'(snk_ready_u), 32'd1);
        check_val("rst_src_valid", 32'(src_valid_u), 32'd0);
        check_val("rst_src_sop_eop", 32'({src_sop_u, src_eop_u}), 32'd0);
        check_val("rst_src_data", 32'(src_data_u), 32'd0);
        check_val("rst_pkt_err", 32'(pkt_err_u), 32'd0);
        check_val("rst_busy", 32'(busy_u), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ascending unsigned, len 5, no bubbles with ready held high
        e0 = err_cnt;
        send(16'd7, 1'b1, 1'b0); send(16'd3, 1'b0, 1'b0); send(16'd9, 1'b0, 1'b0);
        send(16'd1, 1'b0, 1'b0); send(16'd3, 1'b0, 1'b1);
        exp_d[0] = 16'd1; exp_d[1] = 16'd3; exp_d[2] = 16'd3; exp_d[3] = 16'd7; exp_d[4] = 16'd9;
        recv(5, 1'b0);
        check_pkt("asc5", 5);
        check_val("asc5_no_bubble", 32'(last_cyc - first_cyc + 1), 32'd5);
        check_val("asc5_no_err", 32'(err_cnt - e0), 32'd0);
        @(negedge clk);
        check_val("asc5_idle_ready", 32'(snk_ready_u), 32'd1);
        check_val("asc5_idle_busy", 32'(busy_u), 32'd0);

        // 2: descending signed on the 8-bit instance
        sel = 1'b1; sort_desc = 1'b1;
        send(16'h00FF, 1'b1, 1'b0);
        sort_desc = 1'b0;
        send(16'h0002, 1'b0, 1'b0); send(16'h0080, 1'b0, 1'b0); send(16'h0000, 1'b0, 1'b1);
        exp_d[0] = 16'h02; exp_d[1] = 16'h00; exp_d[2] = 16'hFF; exp_d[3] = 16'h80;
        recv(4, 1'b0);
        check_pkt("desc_signed", 4);
        sel = 1'b0;
        @(negedge clk);

        // 3: single word, no sort
        send(16'h00AA, 1'b1, 1'b1);
        exp_d[0] = 16'h00AA;
        recv(1, 1'b0);
        check_pkt("single", 1);
        check_val("single_latency_ok", 32'(first_cyc <= 3), 32'd1);
        @(negedge clk);

        // 4: overflow at beat 17, EOP on beat 20
        e0 = err_cnt; v0 = vld_cnt;
        for (int b = 1; b <= 20; b++) send(16'(b), b == 1, b == 20);
        repeat (10) @(negedge clk);
        check_val("ovf_err_pulses", 32'(err_cnt - e0), 32'd1);
        check_val("ovf_no_output", 32'(vld_cnt - v0), 32'd0);
        check_val("ovf_back_idle", 32'(snk_ready_u), 32'd1);
        send(16'd2, 1'b1, 1'b0); send(16'd1, 1'b0, 1'b1);
        exp_d[0] = 16'd1; exp_d[1] = 16'd2;
        recv(2, 1'b0);
        check_pkt("after_ovf", 2);
        @(negedge clk);

        // 5: full-length reverse input with a toggling sink
        for (int b = 0; b < 16; b++) send(16'(15 - b), b == 0, b == 15);
        for (int k = 0; k < 16; k++) exp_d[k] = 16'(k);
        recv(16, 1'b1);
        check_pkt("rev16", 16);
        check_val("rev16_sort_time_ok", 32'(first_cyc <= 288 + 3), 32'd1);
        @(negedge clk);

        // 6: reset in the middle of sorting
        send(16'd4, 1'b1, 1'b0); send(16'd3, 1'b0, 1'b0);
        send(16'd2, 1'b0, 1'b0); send(16'd1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_val("sorting_busy", 32'(busy_u), 32'd1);
        check_val("sorting_not_ready", 32'(snk_ready_u), 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", 32'(busy_u), 32'd0);
        check_val("midrst_ready", 32'(snk_ready_u), 32'd1);
        check_val("midrst_valid", 32'(src_valid_u), 32'd0);
        check_val("midrst_err", 32'(pkt_err_u), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'd4, 1'b1, 1'b0); send(16'd2, 1'b0, 1'b1);
        exp_d[0] = 16'd2; exp_d[1] = 16'd4;
        recv(2, 1'b0);
        check_pkt("after_rst", 2);
        @(negedge clk);

        // 7: SOP in the middle of a packet restarts it
        e0 = err_cnt;
        send(16'd5, 1'b1, 1'b0); send(16'd6, 1'b0, 1'b0);
        send(16'd9, 1'b1, 1'b0); send(16'd8, 1'b0, 1'b1);
        exp_d[0] = 16'd8; exp_d[1] = 16'd9;
        recv(2, 1'b0);
        check_pkt("restart", 2);
        check_val("restart_err_pulses", 32'(err_cnt - e0), 32'd1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
